pll_reset_seq: RTL

- Sequences the system PLL (50 MHz refclk in; 64/128 MHz out) from power-up to stable operation.
- Drives the PLL reset and watches its lock signal. Retries the PLL when lock does not arrive in time.
- Holds the core reset until lock has been stable for a set time.
- Runs on refclk. Consumers in the PLL output domains resynchronise sys_rst locally.

---
 rtl/pll_reset_seq_pkg.sv | 20 ++
 rtl/pll_reset_seq_sync_bit.sv | 22 ++
 rtl/pll_reset_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_seq_pkg: shared state encoding, default parameters and counter sizing for the PLL reset sequencer
package pll_reset_seq_pkg;

   typedef enum logic [2:0] {PRST, WAIT, STAB, RUN, FAIL} state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 50000;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 7;

   // Width needed for one counter that must reach the largest terminal count minus one
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a > b ? a : b;
      m = m > c ? m : c;
      return m > 1 ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// sync_bit: multi-flop synchroniser for a single asynchronous status bit, clears to 0 on reset
module sync_bit
   import pll_reset_seq_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   // Shift the async input through the chain; the last flop is the safe copy
   always_ff @(posedge clk)
      if (rst) sr <= '0;
      else     sr <= {sr[STAGES-2:0], d};

   assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: brings the PLL out of reset, retries on lock timeout and holds sys_rst until lock is stable.
// Optional PLL_RESET_SEQ_LOSS_CNT_EN adds loss_cnt/lost to report lock losses while running.
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [2:0] retries
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   ,
   output logic [7:0] loss_cnt,
   output logic       lost
`endif
);

   localparam int CW = cnt_w(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
   localparam logic [CW-1:0] RST_TC = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_TC  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] ST_TC  = CW'(STABLE_CYCLES - 1);
   localparam logic [2:0]    MAX_R  = 3'(MAX_RETRIES);

   state_t          state, nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      retries_nxt;
   logic            lk;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   // Next state, shared counter and retry count; the counter clears on every state change
   always_comb begin
      nxt         = state;
      cnt_nxt     = cnt;
      retries_nxt = retries;
      case (state)
         PRST:
            if (cnt == RST_TC) begin
               nxt     = WAIT;
               cnt_nxt = '0;
            end else cnt_nxt = cnt + CW'(1);
         WAIT:
            if (lk) begin
               nxt     = STAB;
               cnt_nxt = '0;
            end else if (cnt == TO_TC) begin
               nxt         = retries == MAX_R ? FAIL : PRST;
               retries_nxt = retries == MAX_R ? retries : retries + 3'd1;
               cnt_nxt     = '0;
            end else cnt_nxt = cnt + CW'(1);
         STAB:
            if (!lk) begin
               nxt     = WAIT;
               cnt_nxt = '0;
            end else if (cnt == ST_TC) begin
               nxt         = RUN;
               cnt_nxt     = '0;
               retries_nxt = '0;
            end else cnt_nxt = cnt + CW'(1);
         RUN:
            if (!lk) begin
               nxt     = WAIT;
               cnt_nxt = '0;
            end
         FAIL: ;
         default: begin
            nxt     = PRST;
            cnt_nxt = '0;
         end
      endcase
   end

   // State, counters and outputs; outputs are decoded from the next state so they align with the state register
   always_ff @(posedge refclk)
      if (rst) begin
         state   <= PRST;
         cnt     <= '0;
         retries <= '0;
         pll_rst <= 1'b1;
         sys_rst <= 1'b1;
         ready   <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= cnt_nxt;
         retries <= retries_nxt;
         pll_rst <= nxt == PRST || nxt == FAIL;
         sys_rst <= nxt != RUN;
         ready   <= nxt == RUN;
         fault   <= fault | (nxt == FAIL);
      end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   logic lose;
   assign lose = state == RUN && nxt == WAIT;

   // Count and flag each drop out of RUN; the count saturates rather than wrapping
   always_ff @(posedge refclk)
      if (rst) begin
         loss_cnt <= '0;
         lost     <= 1'b0;
      end else begin
         lost <= lose;
         if (lose && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
      end
`endif

endmodule
